data_memory_responder: RTL and testbench

- Responder end of the compute core's data-memory interface: accepts one load/store request at a time on MemEn/MemWrite/ByteEn/MemAdr/MemWriteData.
- Services each request against an internal word array after a parameterised latency, then returns MemReadData with a one-cycle MemValid strobe.
- Provides MemReady back-pressure so the core can stall; replaces the ideal external data memory in simulation and FPGA builds.

---
 rtl/data_memory_responder_pkg.sv | 13 +
 rtl/data_memory_responder_if.sv | 27 ++
 rtl/byte_lane_merge.sv | 15 +
 rtl/data_memory_responder.sv | 102 ++++++++++
 tb/tb_data_memory_responder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared types and helpers for the data-memory responder and its bus.
package data_memory_responder_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_resp_state_t;

    localparam int DEFAULT_WORD_SIZE = 32;
    localparam int BYTE_LANES        = DEFAULT_WORD_SIZE / 8;

    function automatic int byte_lanes(input int word_size);
        return word_size / 8;
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Core <-> data-memory request/response bus.
interface data_memory_responder_if
    import data_memory_responder_pkg::*;
#(
    parameter int BIT_COUNT = 32,
    parameter int WORD_SIZE = 32
);
    logic                               MemEn;
    logic                               MemWrite;
    logic [byte_lanes(WORD_SIZE)-1:0]   ByteEn;
    logic [BIT_COUNT-1:0]               MemAdr;
    logic [WORD_SIZE-1:0]               MemWriteData;
    logic                               MemReady;
    logic                               MemValid;
    logic [WORD_SIZE-1:0]               MemReadData;
    logic                               MemFault;

    modport master (
        output MemEn, MemWrite, ByteEn, MemAdr, MemWriteData,
        input  MemReady, MemValid, MemReadData, MemFault
    );

    modport slave (
        input  MemEn, MemWrite, ByteEn, MemAdr, MemWriteData,
        output MemReady, MemValid, MemReadData, MemFault
    );
endinterface

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: enabled lanes take new_word, the rest keep old_word.
module byte_lane_merge
    import data_memory_responder_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0]             old_word,
    input  logic [WORD_SIZE-1:0]             new_word,
    input  logic [byte_lanes(WORD_SIZE)-1:0] byte_en,
    output logic [WORD_SIZE-1:0]             merged
);
    for (genvar i = 0; i < byte_lanes(WORD_SIZE); i++) begin : g_lane
        assign merged[i*8 +: 8] = byte_en[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding data-memory responder with fixed latency and byte-lane stores.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int BIT_COUNT   = 32,
    parameter int WORD_SIZE   = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    data_memory_responder_if.slave  bus
);
    localparam int LANES = byte_lanes(WORD_SIZE);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef struct packed {
        logic                 write;
        logic [LANES-1:0]     byte_en;
        logic [BIT_COUNT-1:0] adr;
        logic [WORD_SIZE-1:0] write_data;
    } mem_request_t;

    mem_resp_state_t      state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    mem_request_t         req;
    logic [WORD_SIZE-1:0] rdata;
    logic                 fault_q;
    logic [WORD_SIZE-1:0] mem [DEPTH_WORDS];

    logic                 ready, accept, finish, fault, mem_we;
    logic [IDX_W-1:0]     idx;
    logic [WORD_SIZE-1:0] old_word, merged;

    assign ready    = (state != BUSY);
    assign accept   = bus.MemEn && ready;
    assign finish   = (state == BUSY) && (cnt == '0);
    assign idx      = req.adr[IDX_W+1:2];
    assign old_word = mem[idx];
    // Out of range, or a full-word store that is not word aligned.
    assign fault    = ((req.adr >> (IDX_W + 2)) != '0) ||
                      (req.write && (req.adr[1:0] != 2'b00) && (&req.byte_en));
    assign mem_we   = finish && req.write && !fault;

    byte_lane_merge #(.WORD_SIZE(WORD_SIZE)) u_merge (
        .old_word (old_word),
        .new_word (req.write_data),
        .byte_en  (req.byte_en),
        .merged   (merged)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: if (accept) begin
                state_nxt = BUSY;
                cnt_nxt   = CNT_W'(LATENCY - 1);
            end
            BUSY: if (cnt == '0) state_nxt = RESP;
                  else           cnt_nxt   = cnt - CNT_W'(1);
            RESP: if (accept) begin
                state_nxt = BUSY;
                cnt_nxt   = CNT_W'(LATENCY - 1);
            end else begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            req     <= '0;
            rdata   <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept)
                req <= '{write: bus.MemWrite, byte_en: bus.ByteEn,
                         adr: bus.MemAdr, write_data: bus.MemWriteData};
            if (finish) begin
                fault_q <= fault;
                rdata   <= fault ? '0 : (req.write ? merged : old_word);
            end
        end
    end

    // Array survives reset; writes are gated by the reset-cleared FSM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= merged;
    end

    assign bus.MemReady    = ready;
    assign bus.MemValid    = (state == RESP);
    assign bus.MemFault    = (state == RESP) && fault_q;
    assign bus.MemReadData = rdata;
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: three responders (LATENCY 2/1/4) against a timestamp-based reference model.
module tb_data_memory_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int lat_m [3] = '{2, 1, 4};
    int dep_m [3] = '{1024, 1024, 256};

    logic        en [3];
    logic        wr [3];
    logic [3:0]  be [3];
    logic [31:0] adr [3];
    logic [31:0] wd [3];
    logic        rdy [3];
    logic        vld [3];
    logic        flt [3];
    logic [31:0] rd [3];

    data_memory_responder_if #(.BIT_COUNT(32), .WORD_SIZE(32)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        localparam int D = (g == 2) ? 256 : 1024;
        assign bus[g].MemEn        = en[g];
        assign bus[g].MemWrite     = wr[g];
        assign bus[g].ByteEn       = be[g];
        assign bus[g].MemAdr       = adr[g];
        assign bus[g].MemWriteData = wd[g];
        assign rdy[g] = bus[g].MemReady;
        assign vld[g] = bus[g].MemValid;
        assign flt[g] = bus[g].MemFault;
        assign rd[g]  = bus[g].MemReadData;
        data_memory_responder #(.BIT_COUNT(32), .WORD_SIZE(32), .DEPTH_WORDS(D), .LATENCY(L)) dut (
            .clk   (clk),
            .reset (rst_n),
            .bus   (bus[g].slave)
        );
    end

    // Reference model: a request accepted at edge c answers at edge c+LATENCY.
    int          cyc = 0;
    bit          m_pend [3];
    int          m_due [3];
    bit          m_ready [3] = '{1'b1, 1'b1, 1'b1};
    bit          m_valid [3];
    bit          m_fault [3];
    logic [31:0] m_data [3] = '{32'h0, 32'h0, 32'h0};
    bit          q_wr [3];
    bit   [3:0]  q_be [3];
    bit   [31:0] q_adr [3];
    bit   [31:0] q_wd [3];
    bit          acc [3];
    bit   [31:0] mmem [longint];

    function automatic void respond(input int k);
        longint key;
        bit     f;
        bit [31:0] w;
        key = longint'(k) * 64'h1_0000_0000 + longint'(q_adr[k] >> 2);
        f = (q_adr[k] >= 32'(dep_m[k] * 4)) ||
            (q_wr[k] && q_adr[k][1:0] != 2'b00 && q_be[k] == 4'hF);
        w = mmem.exists(key) ? mmem[key] : 32'h0;
        m_fault[k] = f;
        if (f) begin
            m_data[k] = 32'h0;
        end else if (q_wr[k]) begin
            for (int b = 0; b < 4; b++)
                if (q_be[k][b]) w[b*8 +: 8] = q_wd[k][b*8 +: 8];
            mmem[key] = w;
            m_data[k] = w;
        end else begin
            m_data[k] = w;
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_pend[k] = 1'b0; m_valid[k] = 1'b0; m_ready[k] = 1'b1;
                m_data[k] = 32'h0; m_fault[k] = 1'b0;
            end else begin
                acc[k] = en[k] && m_ready[k];
                m_valid[k] = 1'b0;
                if (m_pend[k] && cyc == m_due[k]) begin
                    respond(k);
                    m_pend[k] = 1'b0;
                    m_valid[k] = 1'b1;
                end
                if (acc[k]) begin
                    q_wr[k] = wr[k]; q_be[k] = be[k]; q_adr[k] = adr[k]; q_wd[k] = wd[k];
                    m_pend[k] = 1'b1;
                    m_due[k] = cyc + lat_m[k];
                end
                m_ready[k] = !m_pend[k];
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int k = 0; k < 3; k++) begin
                logic [34:0] act, exp;
                act = {rdy[k], vld[k], flt[k], rd[k]};
                if (!rst_n) exp = {1'b1, 1'b0, 1'b0, 32'h0};
                else        exp = {m_ready[k], m_valid[k], m_valid[k] && m_fault[k], m_data[k]};
                n_chk++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL model dut%0d cyc=%0d got rdy/vld/flt/data=%h want %h", k, cyc, act, exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic req(input int k, input bit w, input bit [3:0] b, input bit [31:0] a,
                       input bit [31:0] d, input bit tog,
                       output logic [31:0] rdat, output logic rf, output int lat);
        int n = 0;
        en[k] = 1'b1; wr[k] = w; be[k] = b; adr[k] = a; wd[k] = d;
        while (!rdy[k] && n < 20) begin @(posedge clk); #2; n++; end
        @(posedge clk); #2;
        en[k] = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #2;
            lat++;
            if (vld[k]) break;
            if (tog) begin
                en[k] = ~en[k]; wd[k] = ~wd[k]; adr[k] = adr[k] ^ 32'h4;
            end
        end
        en[k] = 1'b0;
        rdat = rd[k];
        rf = flt[k];
        @(posedge clk); #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] d;
        logic        f;
        int          l, n, vcount;
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; wr[k] = 1'b0; be[k] = 4'h0; adr[k] = 32'h0; wd[k] = 32'h0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        chk("reset ready", rdy[0], 1'b1);
        chk("reset valid", vld[0], 1'b0);
        chk("reset data", rd[0], 32'h0);

        req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, d, f, l);
        chk("store full lat", l, 2);
        chk("store full data", d, 32'hDEADBEEF);
        chk("store full fault", f, 1'b0);
        req(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, d, f, l);
        chk("load full data", d, 32'hDEADBEEF);
        chk("load full fault", f, 1'b0);

        req(0, 1'b1, 4'h1, 32'h10, 32'h000000AA, 1'b0, d, f, l);
        chk("store lane0 data", d, 32'hDEADBEAA);
        req(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, d, f, l);
        chk("load lane0 data", d, 32'hDEADBEAA);
        req(0, 1'b1, 4'hC, 32'h10, 32'h12340000, 1'b0, d, f, l);
        chk("store upper data", d, 32'h1234BEAA);
        req(0, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 1'b0, d, f, l);
        chk("noop store data", d, 32'h1234BEAA);
        chk("noop store fault", f, 1'b0);

        // Back-to-back: MemEn held high across the store's RESP cycle.
        en[0] = 1'b1; wr[0] = 1'b1; be[0] = 4'hF; adr[0] = 32'h20; wd[0] = 32'h55;
        @(posedge clk); #2;
        wr[0] = 1'b0; wd[0] = 32'h0;
        n = 0;
        while (!vld[0] && n < 20) begin @(posedge clk); #2; n++; end
        chk("b2b store lat", n, 2);
        chk("b2b store data", rd[0], 32'h55);
        chk("b2b ready in resp", rdy[0], 1'b1);
        @(posedge clk); #2;
        en[0] = 1'b0;
        chk("b2b ready busy", rdy[0], 1'b0);
        n = 0;
        while (!vld[0] && n < 20) begin @(posedge clk); #2; n++; end
        chk("b2b load lat", n, 2);
        chk("b2b load data", rd[0], 32'h55);
        @(posedge clk); #2;

        req(0, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b0, d, f, l);
        chk("oob load fault", f, 1'b1);
        chk("oob load data", d, 32'h0);
        req(0, 1'b1, 4'hF, 32'h22, 32'hFFFFFFFF, 1'b0, d, f, l);
        chk("misaligned store fault", f, 1'b1);
        req(0, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0, d, f, l);
        chk("after fault data", d, 32'h55);
        chk("after fault fault", f, 1'b0);

        // Reset while BUSY drops the pending store.
        req(0, 1'b1, 4'hF, 32'h40, 32'h11111111, 1'b0, d, f, l);
        en[0] = 1'b1; wr[0] = 1'b1; be[0] = 4'hF; adr[0] = 32'h40; wd[0] = 32'h22222222;
        @(posedge clk); #2;
        en[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset ready", rdy[0], 1'b1);
        chk("midreset valid", vld[0], 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        chk("postreset data", rd[0], 32'h0);
        vcount = 0;
        repeat (8) begin @(posedge clk); #2; if (vld[0]) vcount++; end
        chk("dropped no valid", vcount, 0);
        req(0, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, d, f, l);
        chk("dropped store data", d, 32'h11111111);

        req(1, 1'b1, 4'hF, 32'h8, 32'hCAFEF00D, 1'b1, d, f, l);
        chk("lat1 store lat", l, 1);
        chk("lat1 store data", d, 32'hCAFEF00D);
        req(1, 1'b0, 4'h0, 32'h8, 32'h0, 1'b1, d, f, l);
        chk("lat1 load data", d, 32'hCAFEF00D);

        req(2, 1'b1, 4'hF, 32'h4, 32'h0BADBEEF, 1'b1, d, f, l);
        chk("lat4 store lat", l, 4);
        chk("lat4 store data", d, 32'h0BADBEEF);
        req(2, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1, d, f, l);
        chk("lat4 load lat", l, 4);
        chk("lat4 load data", d, 32'h0BADBEEF);
        req(2, 1'b0, 4'h0, 32'h400, 32'h0, 1'b0, d, f, l);
        chk("lat4 oob fault", f, 1'b1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
